bf_mem_responder: RTL and testbench

Memory-side responder for the Brainfuck processor's multiplexed 8-bit bus: it decodes address and data phases, serves instruction fetches from a program store and tape reads and writes from a data store. It also owns the processor's reset, holding it until a host has loaded a program through a valid/ready byte stream. The block sits between the processor's dedicated outputs and bidirectional pins on one side and a host loader on the other.

---
 rtl/bf_mem_responder.sv | 173 +++++++++++++++++
 tb/tb_bf_mem_responder.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bf_mem_responder.sv
// Memory-side responder for the Brainfuck processor bus: host program loader, program store, tape.
// Optional tape-write monitor outputs are enabled by defining BF_MEM_WRITE_MON_EN.
module bf_mem_responder #(
    parameter int PROG_DEPTH = 64,
    parameter int DATA_DEPTH = 32
) (
    input  logic       clk,
    input  logic       rst_n,
`ifdef BF_MEM_WRITE_MON_EN
    output logic       mon_valid,
    output logic [7:0] mon_addr,
    output logic [7:0] mon_data,
`endif
    input  logic       load_valid,
    output logic       load_ready,
    input  logic [7:0] load_data,
    input  logic       load_last,
    input  logic       host_restart,
    output logic       load_ovf,
    output logic       cpu_rst_n,
    input  logic       bus_write,
    input  logic       bus_addr,
    input  logic       bus_instr,
    input  logic [4:0] bus_pc_ext,
    input  logic [7:0] bus_din,
    output logic [7:0] bus_dout,
    output logic       bus_oe
);

    localparam int PA_W = $clog2(PROG_DEPTH);
    localparam int DA_W = $clog2(DATA_DEPTH);
    localparam int AW   = (PA_W > DA_W) ? PA_W : DA_W;
    localparam int LP_W = PA_W + 1;
    localparam logic [LP_W-1:0] LP_MAX = LP_W'(PROG_DEPTH);
    localparam logic [12:0]     PMASK  = 13'(PROG_DEPTH - 1);
    localparam logic [7:0]      DMASK  = 8'(DATA_DEPTH - 1);

    typedef enum logic {ST_LOAD = 1'b0, ST_RUN = 1'b1} state_t;

    state_t          state_q, state_d;
    logic [LP_W-1:0] lptr_q, lptr_d;
    logic            ovf_q, ovf_d;
    logic            cpu_rst_n_q, cpu_rst_n_d;
    logic [AW-1:0]   aptr_q, aptr_d;
    logic            space_q, space_d;   // 1 = program store, 0 = tape
    logic [7:0]      prog_q [PROG_DEPTH];
    logic [7:0]      prog_d [PROG_DEPTH];
    logic [7:0]      tape_q [DATA_DEPTH];
    logic [7:0]      tape_d [DATA_DEPTH];
    logic            tape_we;
    logic            run;
    logic [7:0]      rd_data;

    always_comb begin
        state_d = state_q;
        lptr_d  = lptr_q;
        ovf_d   = ovf_q;
        aptr_d  = aptr_q;
        space_d = space_q;
        prog_d  = prog_q;
        tape_d  = tape_q;
        tape_we = 1'b0;
        case (state_q)
            ST_LOAD: begin
                if (load_valid) begin
                    // Bytes past the end of the program store are dropped but flagged.
                    if (lptr_q < LP_MAX) begin
                        prog_d[lptr_q[PA_W-1:0]] = load_data;
                        lptr_d = lptr_q + 1'b1;
                    end else begin
                        ovf_d = 1'b1;
                    end
                    if (load_last) begin
                        state_d = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                if (host_restart) begin
                    state_d = ST_LOAD;
                    lptr_d  = '0;
                    ovf_d   = 1'b0;
                    for (int i = 0; i < DATA_DEPTH; i++) begin
                        tape_d[i] = 8'h00;
                    end
                end else if (bus_write) begin
                    if (bus_addr) begin
                        space_d = bus_instr;
                        if (bus_instr) begin
                            aptr_d = AW'({bus_pc_ext, bus_din} & PMASK);
                        end else begin
                            aptr_d = AW'(bus_din & DMASK);
                        end
                    end else if (!space_q) begin
                        tape_d[aptr_q[DA_W-1:0]] = bus_din;
                        tape_we = 1'b1;
                    end
                end
            end
            default: state_d = ST_LOAD;
        endcase
        cpu_rst_n_d = (state_d == ST_RUN);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_LOAD;
            lptr_q      <= '0;
            ovf_q       <= 1'b0;
            cpu_rst_n_q <= 1'b0;
            aptr_q      <= '0;
            space_q     <= 1'b0;
            for (int i = 0; i < PROG_DEPTH; i++) begin
                prog_q[i] <= 8'h00;
            end
            for (int i = 0; i < DATA_DEPTH; i++) begin
                tape_q[i] <= 8'h00;
            end
        end else begin
            state_q     <= state_d;
            lptr_q      <= lptr_d;
            ovf_q       <= ovf_d;
            cpu_rst_n_q <= cpu_rst_n_d;
            aptr_q      <= aptr_d;
            space_q     <= space_d;
            prog_q      <= prog_d;
            tape_q      <= tape_d;
        end
    end

    assign run     = (state_q == ST_RUN);
    assign rd_data = space_q ? prog_q[aptr_q[PA_W-1:0]] : tape_q[aptr_q[DA_W-1:0]];

    // The block only drives when the processor is not driving.
    assign bus_oe     = run & ~bus_write;
    assign bus_dout   = bus_oe ? rd_data : 8'h00;
    assign load_ready = (state_q == ST_LOAD);
    assign load_ovf   = ovf_q;
    assign cpu_rst_n  = cpu_rst_n_q;

`ifdef BF_MEM_WRITE_MON_EN
    logic       mon_valid_q, mon_valid_d;
    logic [7:0] mon_addr_q, mon_addr_d;
    logic [7:0] mon_data_q, mon_data_d;

    always_comb begin
        mon_valid_d = tape_we;
        mon_addr_d  = mon_addr_q;
        mon_data_d  = mon_data_q;
        if (tape_we) begin
            mon_addr_d = 8'(aptr_q[DA_W-1:0]);
            mon_data_d = bus_din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mon_valid_q <= 1'b0;
            mon_addr_q  <= 8'h00;
            mon_data_q  <= 8'h00;
        end else begin
            mon_valid_q <= mon_valid_d;
            mon_addr_q  <= mon_addr_d;
            mon_data_q  <= mon_data_d;
        end
    end

    assign mon_valid = mon_valid_q;
    assign mon_addr  = mon_addr_q;
    assign mon_data  = mon_data_q;
`endif

endmodule

// File: tb/tb_bf_mem_responder.sv
// Directed bench for bf_mem_responder: a default-sized instance and a PROG_DEPTH=4 instance
// for overflow, sharing clock, reset and bus inputs.
module tb_bf_mem_responder;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       load_valid, load_last, host_restart;
    logic [7:0] load_data;
    logic       l4_valid, l4_last, r4_restart;
    logic [7:0] l4_data;
    logic       bus_write, bus_addr, bus_instr;
    logic [4:0] bus_pc_ext;
    logic [7:0] bus_din;

    logic       load_ready, load_ovf, cpu_rst_n, bus_oe;
    logic [7:0] bus_dout;
    logic       l4_ready, ovf4, cpu4_rst_n, oe4;
    logic [7:0] dout4;
`ifdef BF_MEM_WRITE_MON_EN
    logic       mon_valid, mon4_valid;
    logic [7:0] mon_addr, mon_data, mon4_addr, mon4_data;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    bf_mem_responder #(.PROG_DEPTH(64), .DATA_DEPTH(32)) dut (
        .clk(clk), .rst_n(rst_n),
`ifdef BF_MEM_WRITE_MON_EN
        .mon_valid(mon_valid), .mon_addr(mon_addr), .mon_data(mon_data),
`endif
        .load_valid(load_valid), .load_ready(load_ready), .load_data(load_data),
        .load_last(load_last), .host_restart(host_restart), .load_ovf(load_ovf),
        .cpu_rst_n(cpu_rst_n), .bus_write(bus_write), .bus_addr(bus_addr),
        .bus_instr(bus_instr), .bus_pc_ext(bus_pc_ext), .bus_din(bus_din),
        .bus_dout(bus_dout), .bus_oe(bus_oe)
    );

    bf_mem_responder #(.PROG_DEPTH(4), .DATA_DEPTH(32)) dut4 (
        .clk(clk), .rst_n(rst_n),
`ifdef BF_MEM_WRITE_MON_EN
        .mon_valid(mon4_valid), .mon_addr(mon4_addr), .mon_data(mon4_data),
`endif
        .load_valid(l4_valid), .load_ready(l4_ready), .load_data(l4_data),
        .load_last(l4_last), .host_restart(r4_restart), .load_ovf(ovf4),
        .cpu_rst_n(cpu4_rst_n), .bus_write(bus_write), .bus_addr(bus_addr),
        .bus_instr(bus_instr), .bus_pc_ext(bus_pc_ext), .bus_din(bus_din),
        .bus_dout(dout4), .bus_oe(oe4)
    );

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic bus_set(input logic w, input logic a, input logic ins,
                           input logic [4:0] ext, input logic [7:0] d);
        bus_write  = w;
        bus_addr   = a;
        bus_instr  = ins;
        bus_pc_ext = ext;
        bus_din    = d;
    endtask

    initial begin
        rst_n = 1'b0;
        load_valid = 0; load_last = 0; load_data = 0; host_restart = 0;
        l4_valid = 0; l4_last = 0; l4_data = 0; r4_restart = 0;
        bus_set(0, 0, 0, 5'd0, 8'h00);
        #12;
        check("rst_load_ready", {7'd0, load_ready}, 8'd1);
        check("rst_cpu_rst_n", {7'd0, cpu_rst_n}, 8'd0);
        check("rst_load_ovf", {7'd0, load_ovf}, 8'd0);
        check("rst_bus_oe", {7'd0, bus_oe}, 8'd0);
        check("rst_bus_dout", bus_dout, 8'h00);
`ifdef BF_MEM_WRITE_MON_EN
        check("rst_mon_valid", {7'd0, mon_valid}, 8'd0);
`endif
        step();
        rst_n = 1'b1;
        step();

        // Load 0x2B, 0x2E (last)
        load_valid = 1; load_data = 8'h2B; load_last = 0;
        step();
        load_data = 8'h2E; load_last = 1;
        settle();
        check("load_hold_reset", {7'd0, cpu_rst_n}, 8'd0);
        step();
        load_valid = 0; load_last = 0;
        settle();
        check("run_cpu_rst_n", {7'd0, cpu_rst_n}, 8'd1);
        check("run_load_ready", {7'd0, load_ready}, 8'd0);

        // Instruction fetch at 0x001
        bus_set(1, 1, 1, 5'd0, 8'h01);
        settle();
        check("addr_phase_oe", {7'd0, bus_oe}, 8'd0);
        step();
        bus_set(0, 0, 0, 5'd0, 8'h00);
        settle();
        check("fetch_oe", {7'd0, bus_oe}, 8'd1);
        check("fetch_001", bus_dout, 8'h2E);
        bus_set(1, 1, 1, 5'd0, 8'h05);
        step();
        bus_set(0, 0, 0, 5'd0, 8'h00);
        settle();
        check("fetch_unloaded_005", bus_dout, 8'h00);
        // 0x100 wraps to 0 in a 64-byte store
        bus_set(1, 1, 1, 5'd1, 8'h00);
        step();
        bus_set(1, 0, 0, 5'd0, 8'hAA);
        step();
        bus_set(0, 0, 0, 5'd0, 8'h00);
        settle();
        check("fetch_wrap_prog_write_ignored", bus_dout, 8'h2B);

        // Tape read-modify-write at 0x03
        bus_set(1, 1, 0, 5'd0, 8'h03);
        step();
        bus_set(0, 0, 0, 5'd0, 8'h00);
        settle();
        check("tape_03_initial", bus_dout, 8'h00);
        step();
        bus_set(1, 0, 0, 5'd0, 8'h41);
        step();
        bus_set(0, 0, 0, 5'd0, 8'h00);
        settle();
        check("tape_03_after_write", bus_dout, 8'h41);
        bus_set(1, 1, 0, 5'd0, 8'h23);
        step();
        bus_set(0, 0, 0, 5'd0, 8'h00);
        settle();
        check("tape_23_alias", bus_dout, 8'h41);
        // Illegal addr-without-write: drives current data, no latch
        bus_set(0, 1, 0, 5'd0, 8'h05);
        settle();
        check("illegal_addr_read", bus_dout, 8'h41);
        step();
        bus_set(0, 0, 0, 5'd0, 8'h00);
        settle();
        check("illegal_addr_no_latch", bus_dout, 8'h41);

        // Tape write 0x7F to 0x02
        bus_set(1, 1, 0, 5'd0, 8'h02);
        step();
        bus_set(1, 0, 0, 5'd0, 8'h7F);
        step();
        bus_set(0, 0, 0, 5'd0, 8'h00);
        settle();
        check("tape_02", bus_dout, 8'h7F);
`ifdef BF_MEM_WRITE_MON_EN
        check("mon_valid_pulse", {7'd0, mon_valid}, 8'd1);
        check("mon_addr", mon_addr, 8'h02);
        check("mon_data", mon_data, 8'h7F);
`endif
        step();
`ifdef BF_MEM_WRITE_MON_EN
        check("mon_valid_one_cycle", {7'd0, mon_valid}, 8'd0);
`endif
        bus_set(1, 1, 1, 5'd0, 8'h01);
        step();
        bus_set(1, 0, 0, 5'd0, 8'h99);
        step();
        bus_set(0, 0, 0, 5'd0, 8'h00);
        settle();
`ifdef BF_MEM_WRITE_MON_EN
        check("mon_no_prog_pulse", {7'd0, mon_valid}, 8'd0);
`endif
        check("prog_001_unchanged", bus_dout, 8'h2E);

        // Restart in the same cycle as a tape write of 0x55
        bus_set(1, 1, 0, 5'd0, 8'h03);
        step();
        bus_set(1, 0, 0, 5'd0, 8'h55);
        host_restart = 1;
        step();
        host_restart = 0;
        bus_set(0, 0, 0, 5'd0, 8'h00);
        settle();
        check("restart_cpu_rst_n", {7'd0, cpu_rst_n}, 8'd0);
        check("restart_load_ready", {7'd0, load_ready}, 8'd1);
        check("restart_load_ovf", {7'd0, load_ovf}, 8'd0);
        check("restart_oe_off", {7'd0, bus_oe}, 8'd0);
        load_valid = 1; load_data = 8'h2C; load_last = 1;
        step();
        load_valid = 0; load_last = 0;
        settle();
        check("reload_cpu_rst_n", {7'd0, cpu_rst_n}, 8'd1);
        bus_set(1, 1, 0, 5'd0, 8'h03);
        step();
        bus_set(0, 0, 0, 5'd0, 8'h00);
        settle();
        check("tape_03_cleared", bus_dout, 8'h00);
        bus_set(1, 1, 0, 5'd0, 8'h02);
        step();
        bus_set(0, 0, 0, 5'd0, 8'h00);
        settle();
        check("tape_02_cleared", bus_dout, 8'h00);
        bus_set(1, 1, 1, 5'd0, 8'h00);
        step();
        bus_set(0, 0, 0, 5'd0, 8'h00);
        settle();
        check("prog_000_reloaded", bus_dout, 8'h2C);
        bus_set(1, 1, 1, 5'd0, 8'h01);
        step();
        bus_set(0, 0, 0, 5'd0, 8'h00);
        settle();
        check("prog_001_retained", bus_dout, 8'h2E);

        // Overflow on the 4-byte instance
        l4_valid = 1;
        for (int i = 0; i < 6; i++) begin
            l4_data = 8'h11 * 8'(i + 1);
            l4_last = (i == 5);
            step();
            if (i == 4) begin
                check("ovf_on_fifth_byte", {7'd0, ovf4}, 8'd1);
            end
        end
        l4_valid = 0; l4_last = 0;
        settle();
        check("ovf4_flag", {7'd0, ovf4}, 8'd1);
        check("ovf4_run", {7'd0, cpu4_rst_n}, 8'd1);
        for (int i = 0; i < 4; i++) begin
            bus_set(1, 1, 1, 5'd0, 8'(i));
            step();
            bus_set(0, 0, 0, 5'd0, 8'h00);
            settle();
            check($sformatf("ovf4_prog_%0d", i), dout4, 8'h11 * 8'(i + 1));
        end
        r4_restart = 1;
        step();
        r4_restart = 0;
        settle();
        check("ovf4_cleared", {7'd0, ovf4}, 8'd0);
        check("ovf4_reset_cpu", {7'd0, cpu4_rst_n}, 8'd0);

        // Asynchronous reset mid-run
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_cpu", {7'd0, cpu_rst_n}, 8'd0);
        check("async_rst_ready", {7'd0, load_ready}, 8'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
